// File: rtl/riscv_defines.sv
// Shared core definitions: interrupt pending unit register map, sizes and config-bus request.
package riscv_defines;

  localparam int IRQ_NUM  = 32;
  localparam int IRQ_ID_W = 5;

  typedef enum logic [1:0] {
    IRQ_REG_MASK = 2'd0,
    IRQ_REG_EDGE = 2'd1,
    IRQ_REG_PEND = 2'd2,
    IRQ_REG_SET  = 2'd3
  } irq_reg_e;

  typedef struct packed {
    logic               we;
    irq_reg_e           addr;
    logic [IRQ_NUM-1:0] wdata;
  } irq_cfg_req_t;

  function automatic logic [IRQ_NUM-1:0] irq_id_onehot(input logic [IRQ_ID_W-1:0] id);
    logic [IRQ_NUM-1:0] oh;
    oh = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/irq_sync.sv
// Parameterized-width 2-flop synchronizer for asynchronous interrupt sources.
module irq_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/irq_pending_unit.sv
// Interrupt conditioning: sync, edge/level mode, pending/mask registers, ack clear.
// Define IRQ_SYNC_EN to put a 2-flop synchronizer on every source line.
module irq_pending_unit
  import riscv_defines::*;
#(
  parameter int                 NUM_IRQ  = IRQ_NUM,
  parameter logic [NUM_IRQ-1:0] RST_MASK = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_IRQ-1:0]  irq_src_i,
  input  logic                cfg_we_i,
  input  logic [1:0]          cfg_addr_i,
  input  logic [NUM_IRQ-1:0]  cfg_wdata_i,
  output logic [NUM_IRQ-1:0]  cfg_rdata_o,
  input  logic                irq_ack_i,
  input  logic [IRQ_ID_W-1:0] irq_ack_id_i,
  output logic [NUM_IRQ-1:0]  irq_o,
  output logic                irq_pending_o
);

  irq_cfg_req_t       cfg;
  logic [NUM_IRQ-1:0] s, prev_q, rise;
  logic [NUM_IRQ-1:0] mask_q, edge_q, pending_q, pending_d;
  logic [NUM_IRQ-1:0] set_v, clr_v, ack_oh, mode_chg;
  logic               wr_mask, wr_edge, wr_pend, wr_set;

  assign cfg = '{we: cfg_we_i, addr: irq_reg_e'(cfg_addr_i), wdata: cfg_wdata_i};

`ifdef IRQ_SYNC_EN
  irq_sync #(.WIDTH(NUM_IRQ)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (irq_src_i),
    .q_o   (s)
  );
`else
  assign s = irq_src_i;
`endif

  assign wr_mask = cfg.we && (cfg.addr == IRQ_REG_MASK);
  assign wr_edge = cfg.we && (cfg.addr == IRQ_REG_EDGE);
  assign wr_pend = cfg.we && (cfg.addr == IRQ_REG_PEND);
  assign wr_set  = cfg.we && (cfg.addr == IRQ_REG_SET);

  assign rise     = s & ~prev_q;
  assign ack_oh   = irq_ack_i ? irq_id_onehot(irq_ack_id_i) : '0;
  assign set_v    = rise | (wr_set ? cfg.wdata : '0);
  assign clr_v    = ack_oh | (wr_pend ? cfg.wdata : '0);
  assign mode_chg = wr_edge ? (cfg.wdata ^ edge_q) : '0;

  // Set beats clear on edge lines so an edge arriving with its own ack is kept;
  // a mode switch drops whatever was pending under the old mode.
  assign pending_d = ~mode_chg & ((edge_q & ((pending_q & ~clr_v) | set_v)) |
                                  (~edge_q & s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= RST_MASK;
      edge_q    <= '0;
      pending_q <= '0;
      prev_q    <= '0;
    end else begin
      prev_q    <= s;
      pending_q <= pending_d;
      if (wr_mask) mask_q <= cfg.wdata;
      if (wr_edge) edge_q <= cfg.wdata;
    end
  end

  always_comb begin
    cfg_rdata_o = '0;
    case (cfg.addr)
      IRQ_REG_MASK: cfg_rdata_o = mask_q;
      IRQ_REG_EDGE: cfg_rdata_o = edge_q;
      IRQ_REG_PEND: cfg_rdata_o = pending_q;
      default:      cfg_rdata_o = '0;
    endcase
  end

  assign irq_o         = pending_q & mask_q;
  assign irq_pending_o = |irq_o;

endmodule

// File: tb/tb_irq_pending_unit.sv
// Self-checking bench for irq_pending_unit: per-cycle model compare plus directed literal checks.
module tb_irq_pending_unit;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] irq_src_i = '0;
  logic        cfg_we_i = 1'b0;
  logic [1:0]  cfg_addr_i = 2'd0;
  logic [31:0] cfg_wdata_i = '0;
  logic [31:0] cfg_rdata_o;
  logic        irq_ack_i = 1'b0;
  logic [4:0]  irq_ack_id_i = '0;
  logic [31:0] irq_o;
  logic        irq_pending_o;

  int n_cmp = 0;
  int n_err = 0;

  irq_pending_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .irq_src_i     (irq_src_i),
    .cfg_we_i      (cfg_we_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_wdata_i   (cfg_wdata_i),
    .cfg_rdata_o   (cfg_rdata_o),
    .irq_ack_i     (irq_ack_i),
    .irq_ack_id_i  (irq_ack_id_i),
    .irq_o         (irq_o),
    .irq_pending_o (irq_pending_o)
  );

  always #5 clk = ~clk;

  // Reference model: per-line rules applied one line at a time.
  logic [31:0] m_mask, m_edge, m_pend, m_prev, m_sy1, m_sy2;
  always @(posedge clk or negedge rst_n) begin
    logic [31:0] s_now, np;
    if (!rst_n) begin
      m_mask = '0; m_edge = '0; m_pend = '0; m_prev = '0; m_sy1 = '0; m_sy2 = '0;
    end else begin
`ifdef IRQ_SYNC_EN
      s_now = m_sy2;
`else
      s_now = irq_src_i;
`endif
      np = m_pend;
      for (int i = 0; i < 32; i++) begin
        bit rose, sw_set, sw_clr, ackd;
        rose   = s_now[i] && !m_prev[i];
        sw_set = cfg_we_i && cfg_addr_i == 2'd3 && cfg_wdata_i[i];
        sw_clr = cfg_we_i && cfg_addr_i == 2'd2 && cfg_wdata_i[i];
        ackd   = irq_ack_i && (int'(irq_ack_id_i) == i);
        if (cfg_we_i && cfg_addr_i == 2'd1 && cfg_wdata_i[i] != m_edge[i]) np[i] = 1'b0;
        else if (!m_edge[i]) np[i] = s_now[i];
        else if (rose || sw_set) np[i] = 1'b1;
        else if (sw_clr || ackd) np[i] = 1'b0;
      end
      m_pend = np;
      if (cfg_we_i && cfg_addr_i == 2'd0) m_mask = cfg_wdata_i;
      if (cfg_we_i && cfg_addr_i == 2'd1) m_edge = cfg_wdata_i;
      m_prev = s_now;
      m_sy2  = m_sy1;
      m_sy1  = irq_src_i;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] exp_rd;
    if (rst_n) begin
      case (cfg_addr_i)
        2'd0:    exp_rd = m_mask;
        2'd1:    exp_rd = m_edge;
        2'd2:    exp_rd = m_pend;
        default: exp_rd = '0;
      endcase
      chk("model irq_o", irq_o, m_pend & m_mask);
      chk("model irq_pending_o", {31'd0, irq_pending_o}, {31'd0, |(m_pend & m_mask)});
      chk("model cfg_rdata_o", cfg_rdata_o, exp_rd);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we_i = 1'b1; cfg_addr_i = a; cfg_wdata_i = d;
    cyc(1);
    cfg_we_i = 1'b0;
  endtask

  task automatic ack(input logic [4:0] id);
    irq_ack_i = 1'b1; irq_ack_id_i = id;
    cyc(1);
    irq_ack_i = 1'b0;
  endtask

  initial begin
    // Reset values
    #1;
    chk("rst irq_o", irq_o, 32'h0);
    chk("rst irq_pending_o", {31'd0, irq_pending_o}, 32'h0);
    for (int a = 0; a < 4; a++) begin
      cfg_addr_i = 2'(a);
      #1;
      chk("rst rdata", cfg_rdata_o, 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Level mode: latency up and down, ack ignored
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'h0);
    irq_src_i = 32'h8;
    cyc(LAT - 1);
    chk("level before latency", irq_o, 32'h0);
    cyc(1);
    chk("level rise", irq_o, 32'h8);
    ack(5'd3);
    chk("level ack no-op", irq_o, 32'h8);
    irq_src_i = 32'h0;
    cyc(LAT);
    chk("level fall", irq_o, 32'h0);

    // Level->edge mode switch drops pending, no spurious edge after
    irq_src_i = 32'h4;
    cyc(LAT);
    chk("level bit2", irq_o, 32'h4);
    wr(2'd1, 32'h4);
    chk("mode change clears", irq_o, 32'h0);
    cyc(2);
    chk("mode change stays clear", irq_o, 32'h0);
    irq_src_i = 32'h0;
    wr(2'd1, 32'h0);
    cyc(LAT);

    // Edge mode: pulse latches, ack clears
    wr(2'd1, 32'h80);
    irq_src_i = 32'h80;
    cyc(1);
    irq_src_i = 32'h0;
    cyc(LAT + 1);
    chk("edge latch", irq_o, 32'h80);
    cyc(3);
    chk("edge hold", irq_o, 32'h80);
    ack(5'd7);
    chk("edge ack clear", irq_o, 32'h0);

    // New rise coincident with ack is kept
    irq_src_i = 32'h80;
    cyc(1);
    irq_src_i = 32'h0;
    cyc(LAT + 1);
    chk("edge re-latch", irq_o, 32'h80);
    irq_src_i = 32'h80;
    cyc(LAT - 1);
    ack(5'd7);
    chk("set beats ack", irq_o, 32'h80);
    ack(5'd7);
    chk("ack w/o rise", irq_o, 32'h0);
    irq_src_i = 32'h0;
    cyc(LAT);

    // Masked edge latches in pending
    wr(2'd0, 32'h0);
    wr(2'd1, 32'h20);
    irq_src_i = 32'h20;
    cyc(1);
    irq_src_i = 32'h0;
    cyc(LAT + 1);
    chk("masked irq_o", irq_o, 32'h0);
    cfg_addr_i = 2'd2;
    #1;
    chk("masked pending read", cfg_rdata_o, 32'h20);
    chk("masked irq_pending_o", {31'd0, irq_pending_o}, 32'h0);
    wr(2'd0, 32'h20);
    chk("unmask", irq_o, 32'h20);
    chk("unmask irq_pending_o", {31'd0, irq_pending_o}, 32'h1);

    // Software set / W1C
    wr(2'd1, 32'h8000_0000);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd3, 32'h8000_0001);
    chk("sw set", irq_o, 32'h8000_0000);
    cfg_addr_i = 2'd3;
    #1;
    chk("set reads 0", cfg_rdata_o, 32'h0);
    wr(2'd2, 32'h8000_0000);
    chk("w1c", irq_o, 32'h0);
    irq_src_i = 32'h2;
    cyc(LAT);
    wr(2'd2, 32'h2);
    chk("w1c level ignored", irq_o, 32'h2);
    irq_src_i = 32'h0;
    wr(2'd3, 32'h8000_0000);
    cyc(LAT);
    chk("set before reset", irq_o, 32'h8000_0000);

    // Asynchronous reset mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst irq_o", irq_o, 32'h0);
    chk("async rst irq_pending_o", {31'd0, irq_pending_o}, 32'h0);
    cfg_addr_i = 2'd2;
    #1;
    chk("async rst pending", cfg_rdata_o, 32'h0);
    cfg_addr_i = 2'd0;
    #1;
    chk("async rst mask", cfg_rdata_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(2);
    chk("post rst irq_o", irq_o, 32'h0);

    // Mixed traffic, checked by the per-cycle model
    wr(2'd0, 32'hFFFF_0F0F);
    wr(2'd1, 32'h0F0F_0F0F);
    for (int k = 0; k < 80; k++) begin
      irq_src_i    = $urandom;
      irq_ack_i    = 1'($urandom_range(0, 1));
      irq_ack_id_i = 5'($urandom_range(0, 31));
      cfg_addr_i   = 2'($urandom_range(0, 3));
      cfg_we_i     = ($urandom_range(0, 7) == 0) && (cfg_addr_i >= 2'd2);
      cfg_wdata_i  = $urandom;
      cyc(1);
    end
    cfg_we_i = 1'b0;
    irq_ack_i = 1'b0;
    cyc(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
